pipelined_compressor_tree: RTL

Parametrised, pipelined 4:2 compressor tree for the multiplier datapath. Reduces NUM_ROWS unsigned partial-product rows of WIDTH bits to one redundant sum/carry pair, with a register stage after every reduction level. Uses a valid/ready handshake so the multiplier front end and the downstream adder/normaliser can stall it. Successor to the single-bit combinational compressor: generalised in row count and width, and pipelined with back-pressure.

---
 rtl/mult_pkg.sv | 44 ++++
 rtl/compressor_4to2_cell.sv | 22 ++
 rtl/pipelined_compressor_tree.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath: legal row counts, the
// stage valid vector type and the width/offset helpers used to size the
// pipelined compressor tree.
package mult_pkg;

    localparam int ROWS_4  = 4;
    localparam int ROWS_8  = 8;
    localparam int ROWS_16 = 16;

    // Deepest tree (16 rows) has 3 reduction stages plus the optional adder.
    localparam int MAX_STAGES = 4;

    typedef logic [MAX_STAGES-1:0] stage_vec_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = int'(i) + 1;
        end
        return r;
    endfunction

    function automatic bit rows_legal(input int n);
        return (n == ROWS_4) || (n == ROWS_8) || (n == ROWS_16);
    endfunction

    // Every 4:2 level widens its rows by 2 bits.
    function automatic int out_w(input int width, input int rows);
        return width + 2 * (clog2(rows) - 1);
    endfunction

    // Bit offset of the register stage behind level lvl inside the packed
    // pipeline vector (stage l holds rows>>(l+1) rows of width+2*l+2 bits).
    function automatic int stage_off(input int width, input int rows, input int lvl);
        int off;
        off = 0;
        for (int unsigned l = 0; l < 32; l++) begin
            if (int'(l) < lvl) off += (rows >> (l + 1)) * (width + 2 * int'(l) + 2);
        end
        return off;
    endfunction

endpackage

// File: rtl/compressor_4to2_cell.sv
// One-bit 4:2 compressor built from two full adders.
// x1+x2+x3+x4+cin = s + 2*(c+cout); cout depends only on x1..x3, so the
// column-to-column cin/cout chain never ripples.
module compressor_4to2_cell (
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic cin,
    output logic s,
    output logic c,
    output logic cout
);

    logic s1;

    assign s1   = x1 ^ x2 ^ x3;
    assign cout = (x1 & x2) | (x1 & x3) | (x2 & x3);
    assign s    = s1 ^ x4 ^ cin;
    assign c    = (s1 & x4) | (s1 & cin) | (x4 & cin);

endmodule

// File: rtl/pipelined_compressor_tree.sv
// Pipelined 4:2 compressor tree: NUM_ROWS rows of WIDTH bits reduced to a
// redundant sum/carry pair, one register stage per level, valid/ready
// handshake with back-pressure and bubble collapse.
// Optional macro COMP_TREE_FINAL_ADD_EN adds a registered carry-propagate
// stage driving result_o (sum_o = result_o, carry_o = 0).
module pipelined_compressor_tree
    import mult_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int NUM_ROWS = 8,
    localparam int LEVELS   = clog2(NUM_ROWS) - 1,
    localparam int OUT_W    = out_w(WIDTH, NUM_ROWS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_ROWS*WIDTH-1:0] rows_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          sum_o,
    output logic [OUT_W-1:0]          carry_o
`ifdef COMP_TREE_FINAL_ADD_EN
    ,
    output logic [OUT_W-1:0]          result_o
`endif
);

`ifdef COMP_TREE_FINAL_ADD_EN
    localparam int unsigned NSTG = LEVELS + 1;
`else
    localparam int unsigned NSTG = LEVELS;
`endif
    localparam int TOTAL    = stage_off(WIDTH, NUM_ROWS, LEVELS);
    localparam int LAST_OFF = stage_off(WIDTH, NUM_ROWS, LEVELS - 1);

    // All compressor stage registers packed into one vector, level 0 first.
    logic [TOTAL-1:0] stage_q;
    logic [TOTAL-1:0] lvl_d;
    logic [TOTAL-1:0] load_mask;

    stage_vec_t v_q;
    stage_vec_t vin;
    stage_vec_t adv;
    stage_vec_t ld;

    logic [OUT_W-1:0] sum_w;
    logic [OUT_W-1:0] carry_w;
    logic             unused_stage;

    // Stage k may advance if out_ready or any stage from k to the output is
    // empty; computed per stage directly so no bit of adv feeds another.
    always_comb begin
        logic acc;
        acc = 1'b0;
        vin = stage_vec_t'({v_q[MAX_STAGES-2:0], in_valid});
        adv = '0;
        ld  = '0;
        for (int unsigned k = 0; k < NSTG; k++) begin
            acc = out_ready;
            for (int unsigned j = k; j < NSTG; j++) begin
                acc = acc | ~v_q[j];
            end
            adv[k] = acc;
            ld[k]  = acc & vin[k];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[NSTG-1];

    for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
        localparam int RIN  = NUM_ROWS >> lv;
        localparam int WIN  = WIDTH + 2 * lv;
        localparam int WOUT = WIN + 2;
        localparam int ROUT = RIN / 2;
        localparam int OFF  = stage_off(WIDTH, NUM_ROWS, lv);

        logic [RIN*WIN-1:0] lin;

        if (lv == 0) begin : g_src_in
            assign lin = rows_i;
        end else begin : g_src_reg
            assign lin = stage_q[stage_off(WIDTH, NUM_ROWS, lv - 1) +: RIN*WIN];
        end

        assign load_mask[OFF +: ROUT*WOUT] = {(ROUT*WOUT){ld[lv]}};

        for (genvar g = 0; g < RIN / 4; g++) begin : g_grp
            logic [WOUT:0]   chain;
            logic [WOUT-1:0] s_bits;
            logic [WOUT-1:0] c_bits;
            logic            unused_top;

            assign chain[0] = 1'b0;

            for (genvar i = 0; i < WOUT; i++) begin : g_col
                logic [3:0] x;
                if (i < WIN) begin : g_data
                    assign x = {lin[(4*g+3)*WIN+i], lin[(4*g+2)*WIN+i],
                                lin[(4*g+1)*WIN+i], lin[(4*g)*WIN+i]};
                end else begin : g_ext
                    assign x = '0;
                end

                compressor_4to2_cell u_cell (
                    .x1  (x[0]),
                    .x2  (x[1]),
                    .x3  (x[2]),
                    .x4  (x[3]),
                    .cin (chain[i]),
                    .s   (s_bits[i]),
                    .c   (c_bits[i]),
                    .cout(chain[i+1])
                );
            end

            // The two extension columns see only zero inputs, so the top c and
            // the final cout are provably zero and can be dropped.
            assign lvl_d[OFF + (2*g)*WOUT +: WOUT]   = s_bits;
            assign lvl_d[OFF + (2*g+1)*WOUT +: WOUT] = {c_bits[WOUT-2:0], 1'b0};
            assign unused_top = chain[WOUT] ^ c_bits[WOUT-1];
        end
    end

    // Stage valids and data registers: load where the stage advances with
    // valid data, hold otherwise (frozen stages keep their contents).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            stage_q <= '0;
        end else begin
            v_q     <= (v_q & ~adv) | (vin & adv);
            stage_q <= (stage_q & ~load_mask) | (lvl_d & load_mask);
        end
    end

    assign sum_w   = stage_q[LAST_OFF +: OUT_W];
    assign carry_w = stage_q[LAST_OFF + OUT_W +: OUT_W];

`ifdef COMP_TREE_FINAL_ADD_EN
    logic [OUT_W-1:0] result_q;

    // Carry-propagate stage resolving the redundant pair into one word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (ld[LEVELS]) begin
            result_q <= sum_w + carry_w;
        end
    end

    assign sum_o    = result_q;
    assign carry_o  = '0;
    assign result_o = result_q;
`else
    assign sum_o   = sum_w;
    assign carry_o = carry_w;
`endif

    assign unused_stage = ^{v_q, vin, adv, ld};

endmodule
